// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types for the register arbiter.
// Op encoding and FSM states used by reg_arbiter.
package reg_arb_pkg;

  localparam int OPW = 2;

  localparam logic [OPW-1:0] OP_ENC_READ = 2'b00;
  localparam logic [OPW-1:0] OP_ENC_LD   = 2'b01;
  localparam logic [OPW-1:0] OP_ENC_INC  = 2'b10;
  localparam logic [OPW-1:0] OP_ENC_DECR = 2'b11;

  typedef enum logic [OPW-1:0] {
    OP_READ = OP_ENC_READ,
    OP_LD   = OP_ENC_LD,
    OP_INC  = OP_ENC_INC,
    OP_DECR = OP_ENC_DECR
  } op_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select.
// First asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin sequencer sharing one counter
// register among NREQ requesters, 3 cycles per op.
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NREQ     = 4,
  parameter  bit SATURATE = 1'b0,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [2*NREQ-1:0]     REQ_OP,
  input  logic [WIDTH*NREQ-1:0] REQ_DIN,
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  RSP_VALID,
  output logic [IW-1:0]         RSP_ID,
  output logic [WIDTH-1:0]      RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  REG_CLR,
  output logic                  REG_LD,
  output logic                  REG_INC,
  output logic                  REG_DECR,
  output logic [WIDTH-1:0]      REG_DIN,
  input  logic [WIDTH-1:0]      REG_DOUT
);

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    win_idx;
  logic [NREQ-1:0]  win_gnt;
  logic             win_any;
  logic             accept;
  op_t              win_op;
  logic [WIDTH-1:0] win_din;
  logic             win_err;
  logic [IW-1:0]    g_q;
  op_t              op_q;
  logic [WIDTH-1:0] din_q;
  logic             err_q;
  logic [WIDTH-1:0] post;
  logic             issue;

  rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req(REQ_VALID),
    .ptr(ptr_q),
    .gnt(win_gnt),
    .idx(win_idx),
    .any(win_any)
  );

  assign win_op  = op_t'(REQ_OP[{win_idx, 1'b0} +: 2]);
  assign win_din = REQ_DIN[WIDTH*int'(win_idx) +: WIDTH];
  assign issue   = (state_q == S_ISSUE);

  // Gated with RST_N so every output is low while reset is held
  assign REG_CLR = RST_N && (state_q == S_INIT);

  always_comb begin
    win_err = 1'b0;
    if (SATURATE) begin
      unique case (win_op)
        OP_INC:  win_err = &REG_DOUT;
        OP_DECR: win_err = ~|REG_DOUT;
        default: win_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    REQ_READY = '0;
    unique case (state_q)
      S_INIT:  state_d = S_IDLE;
      S_IDLE: begin
        if (win_any) begin
          accept    = 1'b1;
          REQ_READY = win_gnt;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q <= '0;
      g_q   <= '0;
      op_q  <= OP_READ;
      din_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= (win_idx == IW'(NREQ-1)) ?
               '0 : win_idx + IW'(1);
      g_q   <= win_idx;
      op_q  <= win_op;
      din_q <= win_din;
      err_q <= win_err;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      REG_LD   <= 1'b0;
      REG_INC  <= 1'b0;
      REG_DECR <= 1'b0;
      REG_DIN  <= '0;
    end else begin
      REG_LD   <= accept && (win_op == OP_LD);
      REG_INC  <= accept && !win_err &&
                  (win_op == OP_INC);
      REG_DECR <= accept && !win_err &&
                  (win_op == OP_DECR);
      REG_DIN  <= accept ? win_din : '0;
    end
  end

  // Post-op value from the pre-op DOUT, so RSP_DATA can be a flop
  always_comb begin
    post = REG_DOUT;
    if (!err_q) begin
      unique case (op_q)
        OP_LD:   post = din_q;
        OP_INC:  post = REG_DOUT + WIDTH'(1);
        OP_DECR: post = REG_DOUT - WIDTH'(1);
        default: post = REG_DOUT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RSP_VALID <= 1'b0;
      RSP_ID    <= '0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= issue;
      RSP_ID    <= issue ? g_q : '0;
      RSP_DATA  <= issue ? post : '0;
      RSP_ERR   <= issue && err_q;
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: wrap and saturating instances on shared
// stimulus, checked against a queue-based reference model.
module tb_reg_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [N-1:0]   REQ_VALID;
  logic [2*N-1:0] REQ_OP;
  logic [W*N-1:0] REQ_DIN;

  logic [N-1:0] rdy   [2];
  logic         rv    [2];
  logic [1:0]   rid   [2];
  logic [W-1:0] rd    [2];
  logic         re    [2];
  logic         clr   [2];
  logic         ld    [2];
  logic         inc   [2];
  logic         dec   [2];
  logic [W-1:0] rdin  [2];
  logic [W-1:0] rdout [2];

  always #5 CLK = ~CLK;

  reg_arbiter #(.WIDTH(W), .NREQ(N), .SATURATE(1'b0)) dut0 (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP),
    .REQ_DIN(REQ_DIN), .REQ_READY(rdy[0]),
    .RSP_VALID(rv[0]), .RSP_ID(rid[0]),
    .RSP_DATA(rd[0]), .RSP_ERR(re[0]),
    .REG_CLR(clr[0]), .REG_LD(ld[0]),
    .REG_INC(inc[0]), .REG_DECR(dec[0]),
    .REG_DIN(rdin[0]), .REG_DOUT(rdout[0])
  );

  reg_arbiter #(.WIDTH(W), .NREQ(N), .SATURATE(1'b1)) dut1 (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_OP(REQ_OP),
    .REQ_DIN(REQ_DIN), .REQ_READY(rdy[1]),
    .RSP_VALID(rv[1]), .RSP_ID(rid[1]),
    .RSP_DATA(rd[1]), .RSP_ERR(re[1]),
    .REG_CLR(clr[1]), .REG_LD(ld[1]),
    .REG_INC(inc[1]), .REG_DECR(dec[1]),
    .REG_DIN(rdin[1]), .REG_DOUT(rdout[1])
  );

  // The shared Register that lives in the parent
  always @(posedge CLK)
    for (int g = 0; g < 2; g++) begin
      if (clr[g])      rdout[g] <= '0;
      else if (ld[g])  rdout[g] <= rdin[g];
      else if (inc[g]) rdout[g] <= rdout[g] + 8'd1;
      else if (dec[g]) rdout[g] <= rdout[g] - 8'd1;
    end

  typedef struct {
    int id;
    int data;
    int err;
    int due;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];
  int   grants[$];
  int   ncyc  = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int          mp;
  int          cool;
  int          mval [2];
  logic [N-1:0] pend_v;
  logic [1:0]  pend_op  [N];
  logic [7:0]  pend_din [N];
  logic [2:0]  estb [2];
  logic [7:0]  edin;
  logic        eissue;
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string nm, input int g,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h",
               nm, g, act, exp);
    end
  endtask

  task automatic drive();
    REQ_VALID = pend_v;
    for (int i = 0; i < N; i++) begin
      REQ_OP[2*i +: 2]  = pend_op[i];
      REQ_DIN[8*i +: 8] = pend_din[i];
    end
  endtask

  task automatic issue(input int i, input logic [1:0] op,
                       input logic [7:0] din);
    pend_v[i]   = 1'b1;
    pend_op[i]  = op;
    pend_din[i] = din;
  endtask

  // Behaviour of one op on a plain integer register value
  function automatic void model_op(input int inst,
                                   input logic [1:0] op,
                                   input logic [7:0] din,
                                   output int data,
                                   output int err,
                                   output logic [2:0] stb);
    int v;
    bit sat;
    v   = mval[inst];
    sat = (inst == 1);
    err = 0;
    stb = 3'b000;
    case (op)
      2'b00: ;
      2'b01: begin v = int'(din); stb = 3'b100; end
      2'b10:
        if (sat && v == 255) err = 1;
        else begin v = (v + 1) % 256; stb = 3'b010; end
      default:
        if (sat && v == 0) err = 1;
        else begin v = (v + 255) % 256; stb = 3'b001; end
    endcase
    mval[inst] = v;
    data = v;
  endfunction

  task automatic step();
    logic [N-1:0] erdy;
    logic [2:0]   s;
    int           w;
    int           d;
    int           e;
    rsp_t         r;
    @(negedge CLK);
    drive();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("reg_strobes", g,
          {clr[g], ld[g], inc[g], dec[g]}, {1'b0, estb[g]});
      chk("reg_din", g, rdin[g], eissue ? edin : 8'h00);
    end
    estb[0] = 3'b000;
    estb[1] = 3'b000;
    eissue  = 1'b0;
    erdy    = '0;
    if (cool > 0) begin
      cool--;
    end else if (pend_v != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend_v[(mp + k) % N]) w = (mp + k) % N;
      erdy[w] = 1'b1;
      mp      = (w + 1) % N;
      cool    = 2;
      eissue  = 1'b1;
      edin    = pend_din[w];
      for (int g = 0; g < 2; g++) begin
        model_op(g, pend_op[w], pend_din[w], d, e, s);
        estb[g] = s;
        r = '{id: w, data: d, err: e, due: ncyc + 2};
        if (g == 0) q0.push_back(r);
        else        q1.push_back(r);
      end
      pend_v[w] = 1'b0;
    end
    for (int g = 0; g < 2; g++)
      chk("req_ready", g, rdy[g], erdy);
    if (rdy[0] != '0) grants.push_back($clog2(rdy[0]));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pend_v != '0 && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N  = 1'b0;
    pend_v = '0;
    drive();
    q0.delete();
    q1.delete();
    estb[0] = 3'b000;
    estb[1] = 3'b000;
    eissue  = 1'b0;
    cool    = 0;
    #1;
    for (int g = 0; g < 2; g++)
      chk("reset_outputs", g,
          {rdy[g], rv[g], rid[g], rd[g], re[g],
           clr[g], ld[g], inc[g], dec[g], rdin[g]}, 0);
    repeat (2) @(negedge CLK);
    RST_N   = 1'b1;
    mp      = 0;
    mval[0] = 0;
    mval[1] = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("init_clr", g, clr[g], 1);
      chk("init_ready", g, rdy[g], 0);
    end
  endtask

  task automatic mon(input int g);
    rsp_t e;
    bit   due;
    if (g == 0) due = q0.size() > 0 && q0[0].due == ncyc;
    else        due = q1.size() > 0 && q1[0].due == ncyc;
    if (!due) begin
      chk("rsp_idle_valid", g, rv[g], 0);
      chk("rsp_idle_data", g, rd[g], 0);
    end else begin
      if (g == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk("rsp_valid", g, rv[g], 1);
      chk("rsp_id", g, rid[g], e.id);
      chk("rsp_data", g, rd[g], e.data);
      chk("rsp_err", g, re[g], e.err);
    end
  endtask

  always @(negedge CLK) begin
    ncyc++;
    #2;
    mon(0);
    mon(1);
  end

  initial begin
    logic [7:0] pick [5];
    pend_v  = '0;
    mp      = 0;
    cool    = 0;
    mval[0] = 0;
    mval[1] = 0;
    estb[0] = 3'b000;
    estb[1] = 3'b000;
    eissue  = 1'b0;
    edin    = 8'h00;
    for (int i = 0; i < N; i++) begin
      pend_op[i]  = 2'b00;
      pend_din[i] = 8'h00;
    end
    drive();

    do_reset();
    issue(2, 2'b00, 8'h00);
    drain();
    issue(0, 2'b01, 8'h5A);
    drain();
    issue(1, 2'b10, 8'h00);
    drain();

    issue(0, 2'b01, 8'hFF);
    drain();
    issue(1, 2'b10, 8'h00);
    drain();

    do_reset();
    issue(0, 2'b11, 8'h00);
    drain();
    issue(3, 2'b01, 8'h10);
    drain();

    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) issue(i, 2'b00, 8'h00);
    repeat (15) begin
      step();
      pend_v = '1;
    end
    pend_v = '0;
    drain();
    for (int i = 0; i < 5; i++)
      chk("rr_order", 0,
          (grants.size() > i) ? grants[i] : 99,
          exp_order[i]);

    issue(2, 2'b01, 8'hC3);
    drain();
    issue(1, 2'b10, 8'h00);
    for (int n = 0; n < 10 && pend_v[1]; n++) step();
    do_reset();
    issue(1, 2'b00, 8'h00);
    issue(3, 2'b00, 8'h00);
    drain();

    pick = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h80};
    repeat (400) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 2) == 0)
          issue(i, 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0) ?
                pick[$urandom_range(0, 4)] :
                8'($urandom));
      step();
    end
    pend_v = '0;
    drain();

    chk("sb_left", 0, q0.size(), 0);
    chk("sb_left", 1, q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
